sh_pipe_arbiter: RTL
====================

# sh_pipe_arbiter

Round-robin arbiter and tag tracker that shares the fixed-latency 4-bit shift pipeline between N requesters. Each cycle it grants at most one requester, drives that requester's word into the pipeline input, and carries a matching tag alongside it. The returned word is then delivered on a response port labelled with the originating requester's ID. It sits directly in front of the shift pipeline and is the only agent that drives the pipeline's input.

## Interface
- N, default 4: number of requesters, 2..8.
- W, default 4: data width; must equal the pipeline width.
- LAT, default 3: pipeline latency in clock edges from input to output.
- IDW, default $clog2(N): requester ID width.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset; the same rst feeds the pipeline.
- req_valid  in  N  request valid per requester.
- req_data  in  N*W  flattened request words; requester i uses bits [i*W +: W].
- req_ready  out  N  one-hot grant; combinational from req_valid and pointer.
- pipe_in  out  W  word to the pipeline input.
- pipe_out  in  W  word from the pipeline output.
- rsp_valid  out  1  response word valid this cycle.
- rsp_id  out  IDW  requester ID of the response.
- rsp_data  out  W  response word, equal to pipe_out.
- busy  out  1  high while any tag is in flight.

## Operation
- Round-robin pointer ptr (IDW bits):
  - The grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, … wrapping modulo N.
  - At most one req_ready bit is high; req_ready is 0 when no req_valid is set.
- Acceptance: a transfer occurs when req_valid[i] & req_ready[i] are both high in a cycle.
  - pipe_in = req_data[i] in that cycle.
  - ptr ← (i+1) mod N at the edge.
- Idle cycle (no transfer): pipe_in = 0, ptr unchanged.
- Tag pipeline, LAT stages of {v, id}:
  - Stage 0 captures {transfer, granted id} each edge.
  - Stage k captures stage k-1.
  - rsp_valid = v of the last stage; rsp_id = id of the last stage; rsp_data = pipe_out.
  - When rsp_valid=0, rsp_id = 0.
- No response backpressure; the consumer must accept every rsp_valid cycle.
- busy = OR of all tag v bits.
- Requesters must hold req_valid and req_data stable until granted. Dropping req_valid before the grant is legal; the request is simply lost.
- Reset:
  - ptr=0; all tag v=0 and id=0.
  - rsp_valid=0, rsp_id=0, busy=0, pipe_in=0, req_ready=0 while rst=1.
  - Words in flight at reset are discarded: no rsp_valid is emitted for them.

## Timing
- Grant is combinational in the same cycle as req_valid; there is no added request latency.
- A word accepted in cycle t appears with rsp_valid=1 in cycle t+LAT (t+3 with defaults).
- Throughput is one accept per cycle; back-to-back accepts produce back-to-back responses in accept order.
- Pointer update takes effect in cycle t+1.
- rst asserted in cycle t:
  - All outputs are at reset values from cycle t+1.
  - req_ready is forced to 0 combinationally during cycle t.

## Configuration
- SH_PIPE_ARB_LOCK_EN:
  - Defined: adds input req_lock (N bits).
    - If the requester accepted in cycle t has req_lock[i]=1, ptr ← i instead of i+1, so it keeps priority while valid.
    - Lock is released when req_lock[i]=0 at acceptance, or when req_valid[i]=0; in the latter case the next search starts at i+1.
  - Not defined: the port is absent and arbitration is pure round-robin as above.

## Test plan
- Reset, then req_valid=4'b0001, req_data[0]=4'hA for 1 cycle at t → req_ready=4'b0001 at t; rsp_valid=1, rsp_id=0, rsp_data=4'hA at t+3; busy high from t+1 to t+3.
- All four valid continuously, data = 1,2,3,4 per requester → grants cycle 0,1,2,3,0…; responses from t+3 show rsp_id 0,1,2,3,0 with data 1,2,3,4,1.
- ptr=2 with req_valid=4'b0011 → grant requester 0, ptr becomes 1; next cycle with the same valid → grant requester 1.
- Accept 3 words back-to-back, assert rst for 1 cycle immediately after → rst cycle has req_ready=0 and no rsp_valid at any later cycle; busy=0 after reset.
- Idle cycles interleaved (valid pattern 1,0,1) → pipe_in=0 on idle cycle; responses at t+3 and t+5 only.
- With SH_PIPE_ARB_LOCK_EN: requester 1 locked and valid for 4 cycles while 0, 2 and 3 are valid → four consecutive grants to 1; after lock drops, next grant goes to 2.

Source files
------------

// File: rtl/sh_pipe_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency shift pipeline, with a tag
// shift register that labels each returned word. Optional: SH_PIPE_ARB_LOCK_EN adds req_lock.
module sh_pipe_arbiter #(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int LAT = 3,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SH_PIPE_ARB_LOCK_EN
    input  logic [N-1:0]     req_lock,
`endif
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic [W-1:0]     pipe_in,
    input  logic [W-1:0]     pipe_out,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_data,
    output logic             busy
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_inc;
    logic [N-1:0]   grant;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    int             idx;

    logic [LAT-1:0] tag_v;
    logic [IDW-1:0] tag_id [LAT];

    // First valid requester at or after ptr, wrapping modulo N; nothing while in reset.
    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_any && !rst && req_valid[idx]) begin
                gnt_any    = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = IDW'(idx);
            end
        end
    end

    always_comb begin
        pipe_in = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) pipe_in = req_data[i*W +: W];
        end
    end

    assign req_ready = grant;
    assign ptr_inc   = (int'(gnt_id) == N - 1) ? '0 : gnt_id + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
`ifdef SH_PIPE_ARB_LOCK_EN
            ptr <= req_lock[gnt_id] ? gnt_id : ptr_inc;
`else
            ptr <= ptr_inc;
`endif
        end
    end

    // Tags travel in lockstep with the external pipeline; reset drops words in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
        end else begin
            tag_v[0]  <= gnt_any;
            tag_id[0] <= gnt_id;
            for (int k = 1; k < LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign rsp_valid = tag_v[LAT-1] & ~rst;
    assign rsp_id    = rsp_valid ? tag_id[LAT-1] : '0;
    assign rsp_data  = pipe_out;
    assign busy      = (|tag_v) & ~rst;

endmodule
